// File: rtl/stride_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addr_gen_pkg
// Description : Shared types for the strided address generator. Holds the
//               per-channel FSM state encoding and the channel mode encoding.
// Ports       : none (package)
// Options     : none
// Revision    : 1.0 - initial release
// ============================================================================
package addr_gen_pkg;

    // Per-channel controller state, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Channel sequencing mode.
    typedef enum logic {
        ONESHOT = 1'b0,
        WRAP    = 1'b1
    } mode_e;

endpackage : addr_gen_pkg
`default_nettype wire

// File: rtl/stride_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : stride_addr_gen_if
// Description : Address-stream bundle of the strided address generator.
//               master = generator side, slave = consumer side.
// Signals     : addr_o        per-channel address (ImAddrWidth bits each)
//               addr_valid_o  per-channel address valid
//               addr_ready_i  per-channel consumer ready
//               wrap_o        per-channel WRAP rollover pulse
//               done_o        per-channel ONESHOT completion pulse
//               busy_o        per-channel not-idle flag
//               stall_cnt_o   per-channel stall counter (optional)
// Options     : STRIDE_ADDR_GEN_STALL_CNT_EN adds stall_cnt_o
// Revision    : 1.0 - initial release
// ============================================================================
interface stride_addr_gen_if #(
    parameter int CsrDataWidth = 32,
    parameter int NumTotIm     = 1024,
    parameter int NumCh        = 4
);
    localparam int ImAddrWidth = $clog2(NumTotIm);

    logic [NumCh-1:0][ImAddrWidth-1:0]  addr_o;
    logic [NumCh-1:0]                   addr_valid_o;
    logic [NumCh-1:0]                   addr_ready_i;
    logic [NumCh-1:0]                   wrap_o;
    logic [NumCh-1:0]                   done_o;
    logic [NumCh-1:0]                   busy_o;
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
    logic [NumCh-1:0][CsrDataWidth-1:0] stall_cnt_o;
`endif

    modport master (
        input  addr_ready_i,
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
        output stall_cnt_o,
`endif
        output addr_o, addr_valid_o, wrap_o, done_o, busy_o
    );

    modport slave (
        output addr_ready_i,
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
        input  stall_cnt_o,
`endif
        input  addr_o, addr_valid_o, wrap_o, done_o, busy_o
    );

endinterface : stride_addr_gen_if
`default_nettype wire

// File: rtl/stride_addr_gen_channel.sv
`default_nettype none
// ============================================================================
// Module      : addr_gen_channel
// Description : One independent strided-address channel (IDLE/RUN/DONE).
//               Configuration is captured on start and held for the pass.
// Ports       : clk_i, rst_i (async, active-high), en_i (global enable)
//               start_i, clr_i, mode_i           control
//               start_addr_i, count_i, stride_i  configuration (on start)
//               addr_o/addr_valid_o/addr_ready_i address handshake
//               wrap_o, done_o, busy_o           status
//               stall_cnt_o                      optional stall counter
// Options     : STRIDE_ADDR_GEN_STALL_CNT_EN adds stall_cnt_o
// Revision    : 1.0 - initial release
// ============================================================================
module addr_gen_channel
    import addr_gen_pkg::*;
#(
    parameter int CsrDataWidth = 32,
    parameter int ImAddrWidth  = 10
) (
    input  wire                     clk_i,
    input  wire                     rst_i,
    input  wire                     en_i,
    input  wire                     start_i,
    input  wire                     clr_i,
    input  mode_e                   mode_i,
    input  wire  [CsrDataWidth-1:0] start_addr_i,
    input  wire  [CsrDataWidth-1:0] count_i,
    input  wire  [CsrDataWidth-1:0] stride_i,
    input  wire                     addr_ready_i,
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
    output logic [CsrDataWidth-1:0] stall_cnt_o,
`endif
    output logic [ImAddrWidth-1:0]  addr_o,
    output logic                    addr_valid_o,
    output logic                    wrap_o,
    output logic                    done_o,
    output logic                    busy_o
);

    localparam logic [CsrDataWidth-1:0] C_ONE = CsrDataWidth'(1);

    state_e                  state_q, state_d;
    mode_e                   mode_q,  mode_d;
    logic [CsrDataWidth-1:0] idx_q,   idx_d;
    logic [CsrDataWidth-1:0] addr_q,  addr_d;
    logic [CsrDataWidth-1:0] base_q,  base_d;
    logic [CsrDataWidth-1:0] count_q, count_d;
    logic [CsrDataWidth-1:0] stride_q, stride_d;
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
    logic [CsrDataWidth-1:0] stall_q, stall_d;
`endif

    logic w_abort;
    logic w_hs;
    logic w_adv;
    logic w_last;
    logic w_addr_unused;

    // Global disable acts exactly like a per-channel clear.
    assign w_abort = clr_i | ~en_i;
    assign w_hs    = (state_q == RUN) & addr_ready_i;
    // A handshake only advances the pass when no abort/restart overrides it.
    assign w_adv   = w_hs & ~w_abort & ~start_i;
    // count_q is never zero in RUN, so count_q-1 cannot underflow there.
    assign w_last  = (idx_q == (count_q - C_ONE));

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        base_d   = base_q;
        count_d  = count_q;
        stride_d = stride_q;
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
        stall_d  = stall_q;
`endif
        if (w_abort) begin
            state_d = IDLE;
            idx_d   = '0;
            addr_d  = '0;
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
            stall_d = '0;
`endif
        end else if (start_i) begin
            mode_d   = mode_i;
            base_d   = start_addr_i;
            count_d  = count_i;
            stride_d = stride_i;
            idx_d    = '0;
            addr_d   = start_addr_i;
            // An empty pass skips RUN entirely.
            state_d  = (count_i == '0) ? DONE : RUN;
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
            stall_d  = '0;
`endif
        end else begin
            case (state_q)
                RUN: begin
                    if (w_hs) begin
                        if (w_last) begin
                            if (mode_q == WRAP) begin
                                idx_d  = '0;
                                addr_d = base_q;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            idx_d  = idx_q + C_ONE;
                            addr_d = addr_q + stride_q;
                        end
                    end
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
                    else if (stall_q != '1) begin
                        stall_d = stall_q + C_ONE;
                    end
`endif
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mode_q   <= ONESHOT;
            idx_q    <= '0;
            addr_q   <= '0;
            base_q   <= '0;
            count_q  <= '0;
            stride_q <= '0;
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
            stall_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            base_q   <= base_d;
            count_q  <= count_d;
            stride_q <= stride_d;
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
            stall_q  <= stall_d;
`endif
        end
    end

    // Upper address bits are dropped: out-of-range addresses wrap silently.
    assign addr_o        = addr_q[ImAddrWidth-1:0];
    assign w_addr_unused = ^addr_q[CsrDataWidth-1:ImAddrWidth];
    assign addr_valid_o  = (state_q == RUN);
    assign wrap_o        = w_adv & w_last & (mode_q == WRAP);
    assign done_o        = (state_q == DONE);
    assign busy_o        = (state_q != IDLE);
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
    assign stall_cnt_o   = stall_q;
`endif

endmodule : addr_gen_channel
`default_nettype wire

// File: rtl/stride_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : stride_addr_gen
// Description : Multi-channel strided address generator. NumCh independent
//               channels each emit start + k*stride addresses with a
//               valid/ready handshake, in ONESHOT or WRAP mode.
// Ports       : clk_i, rst_i (async, active-high), en_i (global enable)
//               start_i, clr_i, mode_i           per-channel control
//               start_addr_i, count_i, stride_i  per-channel configuration
//               bus (stride_addr_gen_if.master)  address stream + status
// Options     : STRIDE_ADDR_GEN_STALL_CNT_EN adds bus.stall_cnt_o
// Revision    : 1.0 - initial release
// ============================================================================
module stride_addr_gen
    import addr_gen_pkg::*;
#(
    parameter int CsrDataWidth = 32,
    parameter int NumTotIm     = 1024,
    parameter int NumCh        = 4
) (
    input  wire                                 clk_i,
    input  wire                                 rst_i,
    input  wire                                 en_i,
    input  wire  [NumCh-1:0]                    start_i,
    input  wire  [NumCh-1:0]                    clr_i,
    input  wire  [NumCh-1:0]                    mode_i,
    input  wire  [NumCh-1:0][CsrDataWidth-1:0]  start_addr_i,
    input  wire  [NumCh-1:0][CsrDataWidth-1:0]  count_i,
    input  wire  [NumCh-1:0][CsrDataWidth-1:0]  stride_i,
    stride_addr_gen_if.master                   bus
);

    localparam int ImAddrWidth = $clog2(NumTotIm);

    logic [NumCh-1:0][ImAddrWidth-1:0]  w_addr;
    logic [NumCh-1:0]                   w_valid;
    logic [NumCh-1:0]                   w_wrap;
    logic [NumCh-1:0]                   w_done;
    logic [NumCh-1:0]                   w_busy;
    logic [NumCh-1:0]                   w_ready;
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
    logic [NumCh-1:0][CsrDataWidth-1:0] w_stall;
`endif

    assign w_ready = bus.addr_ready_i;

    for (genvar g = 0; g < NumCh; g++) begin : g_ch
        addr_gen_channel #(
            .CsrDataWidth (CsrDataWidth),
            .ImAddrWidth  (ImAddrWidth)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .en_i         (en_i),
            .start_i      (start_i[g]),
            .clr_i        (clr_i[g]),
            .mode_i       (mode_e'(mode_i[g])),
            .start_addr_i (start_addr_i[g]),
            .count_i      (count_i[g]),
            .stride_i     (stride_i[g]),
            .addr_ready_i (w_ready[g]),
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
            .stall_cnt_o  (w_stall[g]),
`endif
            .addr_o       (w_addr[g]),
            .addr_valid_o (w_valid[g]),
            .wrap_o       (w_wrap[g]),
            .done_o       (w_done[g]),
            .busy_o       (w_busy[g])
        );
    end

    assign bus.addr_o       = w_addr;
    assign bus.addr_valid_o = w_valid;
    assign bus.wrap_o       = w_wrap;
    assign bus.done_o       = w_done;
    assign bus.busy_o       = w_busy;
`ifdef STRIDE_ADDR_GEN_STALL_CNT_EN
    assign bus.stall_cnt_o  = w_stall;
`endif

endmodule : stride_addr_gen
`default_nettype wire
